// File: rtl/pipe_adder_pkg.sv
// Shared defaults for the chunked pipelined adder/subtractor.
// The pipeline is one register stage per chunk, so latency equals CHUNKS.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_CHUNKS = 4;

    function automatic int latency(input int chunks);
        return chunks;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit adder slice with carry in/out; one instance per pipeline stage.
module adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int W = DEF_WIDTH / DEF_CHUNKS
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract: chunk k is summed in stage k using the carry
// registered by stage k-1, with valid/ready flow control and a global stall.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CHUNKS = DEF_CHUNKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW   = WIDTH / CHUNKS;
    localparam int LAST = latency(CHUNKS) - 1;

    logic stall;
    logic ovf_d, ovf_q;

    if ((CHUNKS < 1) || ((WIDTH % CHUNKS) != 0)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a positive multiple of CHUNKS");
    end

    for (genvar k = 0; k < CHUNKS; k++) begin : g_st
        // b shrinks by one chunk per stage; w holds finished sum chunks below
        // chunk k and still-unconsumed operand A chunks above it.
        localparam int BW = WIDTH - k * CW;

        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] w_in;
        logic [BW-1:0]    b_in;
        logic [CW-1:0]    s_chunk;
        logic             c_out;
        logic             vld_d, vld_q;
        logic             cy_d, cy_q;
        logic [WIDTH-1:0] w_d, w_q;

        if (k == 0) begin : g_src
            // subtract as a + ~b + ~borrow_in
            assign v_in = in_valid;
            assign c_in = cin ^ sub;
            assign w_in = a;
            assign b_in = sub ? ~b : b;
        end else begin : g_src
            assign v_in = g_st[k-1].vld_q;
            assign c_in = g_st[k-1].cy_q;
            assign w_in = g_st[k-1].w_q;
            assign b_in = g_st[k-1].g_fwd.b_q;
        end

        adder_slice #(.W(CW)) u_slice (
            .a    (w_in[k*CW +: CW]),
            .b    (b_in[CW-1:0]),
            .cin  (c_in),
            .sum  (s_chunk),
            .cout (c_out)
        );

        always_comb begin
            vld_d = vld_q;
            cy_d  = cy_q;
            w_d   = w_q;
            if (!stall) begin
                vld_d              = v_in;
                cy_d               = c_out;
                w_d                = w_in;
                w_d[k*CW +: CW]    = s_chunk;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                w_q   <= '0;
            end else begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                w_q   <= w_d;
            end
        end

        if (k < LAST) begin : g_fwd
            logic [BW-CW-1:0] b_d, b_q;

            always_comb begin
                b_d = b_q;
                if (!stall) b_d = b_in[BW-1:CW];
            end

            always_ff @(posedge clk) begin
                b_q <= b_d;
            end
        end else begin : g_out
            // same-sign operands with a differently-signed result; equivalent
            // to carry-into-MSB xor carry-out
            always_comb begin
                ovf_d = ovf_q;
                if (!stall) begin
                    ovf_d = (w_in[WIDTH-1] == b_in[CW-1]) &&
                            (s_chunk[CW-1] != w_in[WIDTH-1]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign stall     = g_st[LAST].vld_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = g_st[LAST].vld_q;
    assign sum       = g_st[LAST].w_q;
    assign cout      = g_st[LAST].cy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed vectors on CHUNKS=4/1/8 instances, random
// streaming and stall traffic on the CHUNKS=4 instance, and mid-flight reset.
module tb_pipe_adder;

    localparam int W  = 32;
    localparam int ND = 3;

    typedef struct {
        logic          sub;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          cin;
        logic [W-1:0]  es;
        logic          ec;
        logic          eo;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         ov [ND];
    logic         co [ND];
    logic         of [ND];
    logic         ir [ND];
    logic [W-1:0] sm [ND];

    int n_chk  = 0;
    int n_fail = 0;

    vec_t vt [9];

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(W), .CHUNKS(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov[0]), .out_ready(out_ready),
        .sum(sm[0]), .cout(co[0]), .ovf(of[0])
    );

    pipe_adder #(.WIDTH(W), .CHUNKS(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov[1]), .out_ready(out_ready),
        .sum(sm[1]), .cout(co[1]), .ovf(of[1])
    );

    pipe_adder #(.WIDTH(W), .CHUNKS(8)) u_c8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov[2]), .out_ready(out_ready),
        .sum(sm[2]), .cout(co[2]), .ovf(of[2])
    );

    function automatic int ch_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // Reference: unsigned 33-bit arithmetic for sum/carry, signed 64-bit range check for overflow.
    function automatic logic [33:0] ref_fn(input logic s, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic c);
        logic [32:0] u;
        longint      sx, sy, r;
        logic        o;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!s) begin
            u = {1'b0, x} + {1'b0, y} + 33'(c);
            r = sx + sy + longint'(c);
        end else begin
            u = {1'b0, x} - {1'b0, y} - 33'(c);
            u[32] = ~u[32];
            r = sx - sy - longint'(c);
        end
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {o, u[32], u[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One isolated beat into empty pipelines; latency counted in edges from accept.
    task automatic run_vec(input vec_t v, input string tag);
        int          lat [ND];
        logic [33:0] got [ND];
        @(negedge clk);
        in_valid  = 1'b1;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        out_ready = 1'b1;
        #1 chk({tag, " accept"}, 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < ND; i++) begin
            lat[i] = 0;
            got[i] = '0;
        end
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) begin
                if (lat[i] == 0 && ov[i]) begin
                    lat[i] = j;
                    got[i] = {of[i], co[i], sm[i]};
                end
            end
        end
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s latency c%0d", tag, ch_of(i)), 64'(lat[i]), 64'(ch_of(i)));
            chk($sformatf("%s result c%0d", tag, ch_of(i)), 64'(got[i]), 64'({v.eo, v.ec, v.es}));
        end
    endtask

    // Random traffic on the CHUNKS=4 instance against a queue of reference results.
    task automatic run_rand(input int n, input bit toggle, input string tag);
        logic [33:0] expq [$];
        logic [33:0] hold_val = '0;
        logic [33:0] e;
        bit          held = 1'b0;
        bit          pend = 1'b0;
        int          sent = 0, got = 0, cyc = 0, first = -1, last = -1;
        while ((sent < n || expq.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (!pend) begin
                in_valid = (sent < n) && (toggle ? ($urandom_range(0, 3) != 0) : 1'b1);
                a   = $urandom();
                b   = $urandom();
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end
            out_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk({tag, " in_ready"}, 64'(ir[0]), 64'(!(ov[0] && !out_ready)));
            if (held)
                chk({tag, " stall hold"}, 64'({ov[0], of[0], co[0], sm[0]}), 64'({1'b1, hold_val}));
            if (ov[0] && out_ready) begin
                if (expq.size() == 0) begin
                    chk({tag, " unexpected beat"}, 64'(got + 1), 64'(n));
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("%s beat %0d", tag, got), 64'({of[0], co[0], sm[0]}), 64'(e));
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            held     = ov[0] && !out_ready;
            hold_val = {of[0], co[0], sm[0]};
            if (in_valid && ir[0]) begin
                expq.push_back(ref_fn(sub, a, b, cin));
                sent++;
                pend = 1'b0;
            end else begin
                pend = in_valid;
            end
        end
        in_valid = 1'b0;
        chk({tag, " beats delivered"}, 64'(got), 64'(n));
        chk({tag, " queue empty"}, 64'(expq.size()), 64'd0);
        if (!toggle) chk({tag, " one per cycle span"}, 64'(last - first), 64'(n - 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        vt[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vt[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vt[3] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
        vt[4] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vt[6] = '{1'b0, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0003, 1'b0, 1'b0};
        vt[7] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vt[8] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("reset outputs c%0d", ch_of(i)),
                64'({ov[i], of[i], co[i], sm[i]}), 64'd0);
            chk($sformatf("reset in_ready c%0d", ch_of(i)), 64'(ir[i]), 64'd1);
        end
        rst = 1'b0;

        for (int v = 0; v < 9; v++) run_vec(vt[v], $sformatf("vec%0d", v));

        run_rand(100, 1'b0, "stream");
        run_rand(300, 1'b1, "toggle");

        out_ready = 1'b1;
        repeat (12) @(negedge clk);

        // three beats in flight in the CHUNKS=4 pipe, then reset
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = $urandom(); b = $urandom(); cin = 1'b0; sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre-reset not yet out", 64'(ov[0]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("mid reset outputs c%0d", ch_of(i)),
                64'({ov[i], of[i], co[i], sm[i]}), 64'd0);
            chk($sformatf("mid reset in_ready c%0d", ch_of(i)), 64'(ir[i]), 64'd1);
        end
        rst = 1'b0;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) if (ov[i]) stale++;
        end
        chk("stale beats after reset", 64'(stale), 64'd0);
        run_vec(vt[2], "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter CHUNKS, default 4: number of pipeline slices; WIDTH SHALL be a multiple of CHUNKS, else elaboration fails.
REQ-003 clk  input  1  rising-edge clock; the block SHALL use one clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block accepts operand beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add) / borrow-in (sub).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out (add) / not-borrow (sub).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Add: {cout,sum} SHALL equal a + b + cin, computed at WIDTH+1 bits.
REQ-017 Sub: {cout,sum} SHALL equal a + ~b + ~cin, i.e. a - b - cin; cout=1 means no borrow.
REQ-018 ovf SHALL equal carry into bit WIDTH-1 XOR cout.
REQ-019 The datapath SHALL be split into CHUNKS slices of WIDTH/CHUNKS bits; slice k SHALL add chunk k in pipeline stage k, using the registered carry from stage k-1.
REQ-020 Operand chunks not yet consumed SHALL be skewed forward through stage registers; completed sum chunks SHALL be carried along to the output register.
REQ-021 Latency: a beat accepted at edge N SHALL present out_valid at edge N+CHUNKS, provided no stall occurs.
REQ-022 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-023 Handshake: transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-024 Stall = out_valid && !out_ready; during stall every stage register, including valid bits, SHALL hold.
REQ-025 in_ready SHALL equal !stall, combinationally.
REQ-026 Empty stages (valid bit 0) SHALL advance when not stalled, so pipeline bubbles collapse toward the output.
REQ-027 sum, cout and ovf SHALL remain stable while out_valid && !out_ready.
REQ-028 CHUNKS=1 SHALL give a single registered stage with latency 1.
REQ-029 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated.

Reset
REQ-030 On rst=1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0. sum, cout and ovf SHALL clear to 0.
REQ-031 Reset applied mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 in the first cycle after reset.
REQ-032 Data registers other than the outputs are not required to reset.

Structure
REQ-033 A shared package pipe_adder_pkg SHALL hold the WIDTH/CHUNKS defaults and a latency constant or function equal to CHUNKS.
REQ-034 One sub-module, adder_slice, SHALL implement a combinational (WIDTH/CHUNKS)-bit adder with cin and cout. It SHALL be instantiated once per stage.

Verification
REQ-035 WIDTH=32, CHUNKS=4, add 0x00000000+0x00000000, cin=0 -> sum=0x00000000, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
REQ-036 Add 0xFFFFFFFF+0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0 (carry ripples across all slices). Add 0x7FFFFFFF+0x00000001 -> sum=0x80000000, cout=0, ovf=1.
REQ-037 Sub 5-3, cin=0 -> sum=0x00000002, cout=1. Sub 3-5, cin=0 -> sum=0xFFFFFFFE, cout=0. Sub 0x80000000-1 -> sum=0x7FFFFFFF, ovf=1.
REQ-038 Stream 100 back-to-back random beats with out_ready=1 -> one result per cycle, in order, each matching a WIDTH+1-bit reference model.
REQ-039 Random out_ready toggling (about 50%) -> no loss or duplication of beats; output held stable while stalled; in_ready low exactly when stalled.
REQ-040 Assert rst with 3 beats in flight -> out_valid=0 the next cycle, no stale beat ever emerges; the next accepted beat returns after 4 cycles. Repeat REQ-035 to REQ-037 with CHUNKS=1 and CHUNKS=8.
